// File: rtl/darkedram_axi_pkg.sv
// darkedram_pkg: shared state encoding and AXI constants for the external-RAM bridge.
package darkedram_pkg;
   typedef enum logic [2:0] {IDLE, WREQ, WRSP, RREQ, RRSP, ACK} edram_state_t;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [3:0] STRB_FULL   = 4'hF;
endpackage

// File: rtl/darkedram_axi_if.sv
// darkedram_axi_if: core device-bus port and AXI4-Lite master port for the external-RAM bridge.
interface darkedram_bus_if;
   logic        en, re, we;
   logic [31:0] addr, wdata, rdata;
   logic        doe, wack, rack;
   wire  [31:0] data;
   // rdata is only visible on the shared data lines while the bridge owns them
   assign data = doe ? rdata : 32'bz;
   modport cons (input en, re, we, addr, wdata, output rdata, doe, wack, rack);
   modport prod (output en, re, we, addr, wdata, input rdata, doe, wack, rack, data);
endinterface

interface darkedram_axi_if;
   logic [31:0] awaddr;
   logic        awvalid, awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid, wready;
   logic [1:0]  bresp;
   logic        bvalid, bready;
   logic [31:0] araddr;
   logic        arvalid, arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid, rready;
   logic [2:0]  axprot;
   modport master (output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready, axprot,
                   input awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid);
   modport slave (input awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready, axprot,
                  output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid);
endinterface

// File: rtl/darkedram_axi.sv
// darkedram_axi: turns each darkriscv device-bus request into one AXI4-Lite transaction,
// stalling the core by holding back WACK/RACK until the AXI response arrives.
module darkedram_axi
   import darkedram_pkg::*;
#(
   parameter logic [31:0] ADDR_MASK = 32'hFFFF_FFFC
) (
   input  logic            XCLK,
   input  logic            XRES,
   darkedram_bus_if.cons   bus,
   input  logic [3:0]      be_i,
   darkedram_axi_if.master axi,
   output logic            err_o
);
   edram_state_t state_q, state_d;
   logic [31:0]  addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
   logic [3:0]   strb_q, strb_d;
   logic         awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
   logic         arvalid_q, arvalid_d, rready_q, rready_d;
   logic         aw_done_q, aw_done_d, w_done_q, w_done_d;
   logic         rd_q, rd_d, err_q, err_d;

   always_ff @(posedge XCLK or negedge XRES) begin
      if (!XRES) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         strb_q    <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         rd_q      <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         strb_q    <= strb_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         bready_q  <= bready_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         rd_q      <= rd_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      strb_d    = strb_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      bready_d  = bready_q;
      arvalid_d = arvalid_q;
      rready_d  = rready_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      rd_d      = rd_q;
      err_d     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.en && bus.we) begin
               addr_d    = bus.addr & ADDR_MASK;
               wdata_d   = bus.wdata;
               strb_d    = (be_i == 4'b0000) ? STRB_FULL : be_i;
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               rd_d      = 1'b0;
               state_d   = WREQ;
            end else if (bus.en && bus.re) begin
               addr_d    = bus.addr & ADDR_MASK;
               arvalid_d = 1'b1;
               rd_d      = 1'b1;
               state_d   = RREQ;
            end
         end
         WREQ: begin
            // AW and W retire independently; B is only accepted once both have
            aw_done_d = aw_done_q | (awvalid_q & axi.awready);
            w_done_d  = w_done_q | (wvalid_q & axi.wready);
            awvalid_d = awvalid_q & ~axi.awready;
            wvalid_d  = wvalid_q & ~axi.wready;
            if (aw_done_d && w_done_d) begin
               bready_d = 1'b1;
               state_d  = WRSP;
            end
         end
         WRSP: begin
            if (axi.bvalid) begin
               bready_d = 1'b0;
               err_d    = axi.bresp != RESP_OKAY;
               state_d  = ACK;
            end
         end
         RREQ: begin
            if (axi.arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = RRSP;
            end
         end
         RRSP: begin
            if (axi.rvalid) begin
               rdata_d  = axi.rdata;
               rready_d = 1'b0;
               err_d    = axi.rresp != RESP_OKAY;
               state_d  = ACK;
            end
         end
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // a request dropped mid-transaction still finishes on AXI but gets no ack here
   assign bus.wack  = (state_q == ACK) & ~rd_q & bus.en & bus.we;
   assign bus.rack  = (state_q == ACK) & rd_q & bus.en & bus.re;
   assign bus.doe   = bus.rack;
   assign bus.rdata = rdata_q;

   assign axi.awaddr  = addr_q;
   assign axi.araddr  = addr_q;
   assign axi.awvalid = awvalid_q;
   assign axi.wdata   = wdata_q;
   assign axi.wstrb   = strb_q;
   assign axi.wvalid  = wvalid_q;
   assign axi.bready  = bready_q;
   assign axi.arvalid = arvalid_q;
   assign axi.rready  = rready_q;
   assign axi.axprot  = 3'b000;
   assign err_o       = err_q;
endmodule

// File: doc/darkedram_axi.md
# darkedram_axi

External-RAM bridge for the darkriscv data path: consumes the same device-bus requests the on-chip RAM serves and turns each into a single AXI4-Lite transaction toward external memory. The bridge stalls the core by withholding WACK/RACK until the AXI response returns. It is instantiated in place of the block-RAM array when `_EXTERNAL_RAM_` is defined.

## Interface
- ADDR_MASK, 32'hFFFF_FFFC: ANDed with BUS.ADDR to form the AXI address; keeps accesses word-aligned.
- XCLK  in  1  system clock; every register in the block uses this clock.
- XRES  in  1  asynchronous, active-low reset.
- BUS  device_bus.cons  —  core request port: EN, RE, WE, ADDR[31:0], DATA[31:0] (tristate), WACK, RACK.
- BE  in  4  byte enables for writes; 4'b0000 means full word.
- AWADDR/AWVALID/AWREADY  out/out/in  32/1/1  AXI write address.
- WDATA/WSTRB/WVALID/WREADY  out/out/out/in  32/4/1/1  AXI write data.
- BRESP/BVALID/BREADY  in/in/out  2/1/1  AXI write response.
- ARADDR/ARVALID/ARREADY  out/out/in  32/1/1  AXI read address.
- RDATA/RRESP/RVALID/RREADY  in/in/in/out  32/2/1/1  AXI read data.
- AXPROT  out  3  constant 3'b000; drives both AWPROT and ARPROT.
- ERR  out  1  one-cycle pulse on a non-OKAY BRESP or RRESP.

## Operation
- States: IDLE, WREQ, WRSP, RREQ, RRSP, ACK.
- IDLE with EN&WE: latch addr&ADDR_MASK, DATA, and strb = (BE==0 ? 4'hF : BE). Assert AWVALID and WVALID together, then go to WREQ. WE takes priority when WE and RE are both high.
- IDLE with EN&RE&!WE: latch the address, assert ARVALID, then go to RREQ.
- WREQ: each of AWVALID and WVALID drops individually on its own handshake; done flags track both. Once both are done, assert BREADY and go to WRSP.
- WRSP: on BVALID, drop BREADY, set ERR if BRESP!=2'b00, then go to ACK.
- RREQ: on ARREADY, drop ARVALID, assert RREADY, then go to RRSP.
- RRSP: on RVALID, capture RDATA into the read-data register (the captured value is used even on error), drop RREADY, set ERR if RRESP!=2'b00, then go to ACK.
- ACK, one cycle: WACK = EN&WE for a write, RACK = EN&RE for a read. BUS.DATA is driven with the read-data register only when ACK, read, and EN&RE are all true; otherwise BUS.DATA is high-Z. Return to IDLE.
- Write data is taken only from the latch, never from live BUS.DATA after IDLE.
- EN drop mid-transaction: the AXI transaction always completes (VALIDs are never withdrawn). The ACK cycle produces no WACK/RACK, and the result is discarded.

## Timing
- Reset values: all VALID/READY outputs 0; ERR=0; WACK=RACK=0; BUS.DATA high-Z; state IDLE; latches 0.
- Reset mid-transaction clears everything immediately, including any outstanding AXI beat. The external slave is reset by the same XRES.
- Minimum write latency with all READYs high: request cycle n, AW/W issued n+1, B n+2, WACK n+3.
- Minimum read latency: request cycle n, AR issued n+1, R n+2, RACK with data n+3.
- WACK, RACK and ERR are registered one-cycle pulses. The core holds the request stable until the ack.
- A new request is sampled only in IDLE, so at most one transaction is outstanding. Back-to-back requests cost 4 cycles each at best.
- AW and W may complete in either order or in the same cycle. A VALID never depends combinationally on the matching READY.

## Structure
- darkedram_pkg holds: the state enum (edram_state_t), the RESP constants (RESP_OKAY=2'b00, RESP_SLVERR=2'b10), and the default full-word strobe 4'hF.
- The block is a single module with no sub-module; the FSM and latches are flat.

## Test plan
- Write A=0x100, DATA=0xA5A5_1234, BE=4'b0011 → AWADDR=0x100, WSTRB=4'b0011, WDATA=0xA5A5_1234; WACK 3 cycles after the request; ERR=0.
- Write A=0x104, BE=0 → WSTRB=4'hF. Then read 0x104 with RDATA=0xCAFE_F00D → BUS.DATA=0xCAFE_F00D while RACK=1, and high-Z on the next cycle.
- Write with AWREADY delayed 5 cycles and WREADY immediate → WVALID drops after 1 cycle, AWVALID stays asserted 5 cycles, BREADY asserts only after both handshakes complete, WACK follows B.
- Read answered with RRESP=SLVERR → ERR pulses for one cycle and RACK still asserts with the returned data.
- EN and WE both high → write performed, no ARVALID. Next request in the immediately following cycle is accepted.
- XRES asserted while in WREQ → AWVALID=WVALID=0 within the same cycle, state IDLE. After release, a read completes normally.
